// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller: state encoding,
// opcode/func constants and a small opcode classification helper.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESET   = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_MEM     = 3'd4,
    ST_WB      = 3'd5,
    ST_HALT    = 3'd6,
    ST_FAULT   = 3'd7
  } state_t;

  localparam logic [5:0] OP_LW        = 6'b100011;
  localparam logic [5:0] OP_SW        = 6'b101011;
  localparam logic [5:0] OP_BEQ       = 6'b000100;
  localparam logic [5:0] OP_BNE       = 6'b000101;
  localparam logic [5:0] OP_J         = 6'b000010;
  localparam logic [5:0] OP_JAL       = 6'b000011;
  localparam logic [5:0] FUNC_SYSCALL = 6'b001100;

  // Conditional branches resolve in EXECUTE and return straight to FETCH.
  function automatic logic is_branch(input logic [5:0] opcode);
    return (opcode == OP_BEQ) || (opcode == OP_BNE);
  endfunction

  // Loads and stores need the MEM state.
  function automatic logic is_mem_access(input logic [5:0] opcode);
    return (opcode == OP_LW) || (opcode == OP_SW);
  endfunction

endpackage

// File: rtl/multicycle_controller_stall_timer.sv
// Wait-state watchdog: counts consecutive not-ready cycles of a memory wait
// and flags when the last permitted cycle has been reached.
module multicycle_controller_stall_timer #(
  parameter int STALL_LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LAST_COUNT = 8'(STALL_LIMIT - 1);

  logic [7:0] count;

  // Clear wins over increment so every new state starts its wait at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  assign expired = (count == LAST_COUNT);

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: FETCH/DECODE/EXECUTE/MEM/WB sequencing with
// memory-stall fault trap and SYSCALL halt trap. Only the state register and
// the stall counter are flops; every control output decodes combinationally
// from the state and the ready inputs.
// Optional build macro: MULTICYCLE_CONTROLLER_PERF_COUNTERS_EN enables the
// cycle and retired-instruction counters; otherwise those ports read 0.
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int STALL_LIMIT = 16
) (
  input  logic        multicycle_controller_clk_in,
  input  logic        multicycle_controller_rst_n_in,
  input  logic [5:0]  multicycle_controller_opcode_in,
  input  logic [5:0]  multicycle_controller_func_in,
  input  logic        multicycle_controller_r_type_in,
  input  logic        multicycle_controller_i_type_in,
  input  logic        multicycle_controller_j_type_in,
  input  logic        multicycle_controller_imem_ready_in,
  input  logic        multicycle_controller_dmem_ready_in,
  output logic        multicycle_controller_imem_req_out,
  output logic        multicycle_controller_dmem_req_out,
  output logic        multicycle_controller_dmem_we_out,
  output logic        multicycle_controller_ir_write_out,
  output logic        multicycle_controller_pc_write_out,
  output logic        multicycle_controller_alu_en_out,
  output logic        multicycle_controller_reg_write_out,
  output logic [2:0]  multicycle_controller_state_out,
  output logic        multicycle_controller_halt_out,
  output logic        multicycle_controller_fault_out,
  output logic [31:0] multicycle_controller_cycle_count_out,
  output logic [31:0] multicycle_controller_instret_count_out
);

  logic   clk;
  logic   rst_n;
  logic   [5:0] opcode;
  state_t state;
  state_t state_next;
  logic   stall_clear;
  logic   stall_enable;
  logic   stall_expired;
  logic   unused_inputs;

  assign clk    = multicycle_controller_clk_in;
  assign rst_n  = multicycle_controller_rst_n_in;
  assign opcode = multicycle_controller_opcode_in;

  // The I-type flag carries no information the opcode does not already give.
  assign unused_inputs = multicycle_controller_i_type_in;

  // Next-state selection and combinational control decode.
  always_comb begin
    state_next   = state;
    multicycle_controller_imem_req_out  = 1'b0;
    multicycle_controller_dmem_req_out  = 1'b0;
    multicycle_controller_dmem_we_out   = 1'b0;
    multicycle_controller_ir_write_out  = 1'b0;
    multicycle_controller_pc_write_out  = 1'b0;
    multicycle_controller_alu_en_out    = 1'b0;
    multicycle_controller_reg_write_out = 1'b0;
    multicycle_controller_halt_out      = 1'b0;
    multicycle_controller_fault_out     = 1'b0;
    stall_enable = 1'b0;
    unique case (state)
      ST_RESET: begin
        state_next = ST_FETCH;
      end
      ST_FETCH: begin
        multicycle_controller_imem_req_out = 1'b1;
        if (multicycle_controller_imem_ready_in) begin
          // Latch the instruction and advance PC by 4 in the same cycle.
          multicycle_controller_ir_write_out = 1'b1;
          multicycle_controller_pc_write_out = 1'b1;
          state_next = ST_DECODE;
        end else begin
          stall_enable = 1'b1;
          if (stall_expired) state_next = ST_FAULT;
        end
      end
      ST_DECODE: begin
        if (multicycle_controller_j_type_in) begin
          multicycle_controller_pc_write_out = 1'b1;
          state_next = ST_FETCH;
        end else if (multicycle_controller_r_type_in &&
                     (multicycle_controller_func_in == FUNC_SYSCALL)) begin
          state_next = ST_HALT;
        end else begin
          state_next = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        multicycle_controller_alu_en_out = 1'b1;
        if (is_mem_access(opcode)) begin
          state_next = ST_MEM;
        end else if (is_branch(opcode)) begin
          // The datapath qualifies this write with the compare result.
          multicycle_controller_pc_write_out = 1'b1;
          state_next = ST_FETCH;
        end else begin
          state_next = ST_WB;
        end
      end
      ST_MEM: begin
        multicycle_controller_dmem_req_out = 1'b1;
        multicycle_controller_dmem_we_out  = (opcode == OP_SW);
        if (multicycle_controller_dmem_ready_in) begin
          state_next = (opcode == OP_SW) ? ST_FETCH : ST_WB;
        end else begin
          stall_enable = 1'b1;
          if (stall_expired) state_next = ST_FAULT;
        end
      end
      ST_WB: begin
        multicycle_controller_reg_write_out = 1'b1;
        state_next = ST_FETCH;
      end
      ST_HALT: begin
        multicycle_controller_halt_out = 1'b1;
      end
      ST_FAULT: begin
        multicycle_controller_fault_out = 1'b1;
      end
      default: begin
        state_next = ST_RESET;
      end
    endcase
  end

  assign stall_clear = (state_next != state);

  // State register; asynchronous reset returns to RESET, dropping all requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RESET;
    end else begin
      state <= state_next;
    end
  end

  assign multicycle_controller_state_out = state;

  multicycle_controller_stall_timer #(
    .STALL_LIMIT(STALL_LIMIT)
  ) u_stall_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (stall_clear),
    .enable  (stall_enable),
    .expired (stall_expired)
  );

`ifdef MULTICYCLE_CONTROLLER_PERF_COUNTERS_EN
  logic [31:0] cycle_count;
  logic [31:0] instret_count;
  logic        active;
  logic        retire;

  assign active = (state != ST_RESET) && (state != ST_HALT) && (state != ST_FAULT);
  // An instruction completes when control returns to FETCH from any
  // execution state; the RESET->FETCH entry and FETCH stalls do not count.
  assign retire = (state_next == ST_FETCH) &&
                  ((state == ST_DECODE) || (state == ST_EXECUTE) ||
                   (state == ST_MEM) || (state == ST_WB));

  // Free-running performance counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count   <= '0;
      instret_count <= '0;
    end else begin
      if (active) cycle_count   <= cycle_count + 32'd1;
      if (retire) instret_count <= instret_count + 32'd1;
    end
  end

  assign multicycle_controller_cycle_count_out   = cycle_count;
  assign multicycle_controller_instret_count_out = instret_count;
`else
  assign multicycle_controller_cycle_count_out   = '0;
  assign multicycle_controller_instret_count_out = '0;
`endif

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore/Mealy FSM that sequences the multicycle MIPS datapath through fetch, decode, execute, memory and writeback.
- Consumes opcode, func and type flags from the instruction decoder.
- Drives instruction/data memory request handshakes and datapath write enables.
- Detects memory stalls that never complete and traps in a sticky fault state; traps a SYSCALL in a sticky halt state.

Parameters:
- STALL_LIMIT, 16, maximum consecutive cycles a memory wait state may wait for ready before faulting; legal range 2..255.

Ports:
- multicycle_controller_clk_in  input  1  single clock, rising edge
- multicycle_controller_rst_n_in  input  1  asynchronous, active-low reset
- multicycle_controller_opcode_in  input  6  inst[31:26] from decoder
- multicycle_controller_func_in  input  6  inst[5:0], valid only for R-type
- multicycle_controller_r_type_in  input  1  decoder R-type flag
- multicycle_controller_i_type_in  input  1  decoder I-type flag
- multicycle_controller_j_type_in  input  1  decoder J-type flag
- multicycle_controller_imem_ready_in  input  1  instruction word valid this cycle
- multicycle_controller_dmem_ready_in  input  1  data access complete this cycle
- multicycle_controller_imem_req_out  output  1  instruction fetch request
- multicycle_controller_dmem_req_out  output  1  data access request
- multicycle_controller_dmem_we_out  output  1  data access is a store
- multicycle_controller_ir_write_out  output  1  latch instruction register
- multicycle_controller_pc_write_out  output  1  update PC
- multicycle_controller_alu_en_out  output  1  ALU operates this cycle
- multicycle_controller_reg_write_out  output  1  register file write
- multicycle_controller_state_out  output  3  current state encoding
- multicycle_controller_halt_out  output  1  sticky halt
- multicycle_controller_fault_out  output  1  sticky stall fault

Behaviour:
- States and encodings: RESET=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WB=5, HALT=6, FAULT=7.
- The state register is the only flop besides the stall counter. All other outputs decode combinationally from the state and the ready inputs.
- Reset (asynchronous assert): state=RESET, stall counter=0, every output 0.
- RESET -> FETCH on the first clock edge after reset release.
- FETCH:
  - imem_req=1.
  - If imem_ready=1: ir_write=1 and pc_write=1 (PC+4) in that same cycle; next state DECODE.
  - Otherwise hold.
- DECODE, 1 cycle:
  - j_type=1: pc_write=1 (jump target); next state FETCH.
  - R-type with func=001100 (SYSCALL): next state HALT.
  - Otherwise: next state EXECUTE.
- EXECUTE, 1 cycle, alu_en=1:
  - opcode 100011 (LW) or 101011 (SW): next state MEM.
  - opcode 000100/000101 (BEQ/BNE): pc_write=1 (datapath gates on the compare result); next state FETCH.
  - Otherwise: next state WB.
- MEM:
  - dmem_req=1; dmem_we=1 iff opcode=101011.
  - On dmem_ready=1: SW goes to FETCH, LW goes to WB.
  - dmem_req is held high continuously until ready.
- WB, 1 cycle: reg_write=1; next state FETCH.
- Stall counter:
  - Cleared on every state transition.
  - Increments each FETCH/MEM cycle with ready=0.
  - If the counter equals STALL_LIMIT-1 and ready=0, next state is FAULT. Ready therefore must arrive within the first STALL_LIMIT cycles of the wait.
  - Ready in the same cycle the limit is reached completes normally.
- HALT and FAULT are absorbing until reset:
  - All request and enable outputs are 0.
  - halt_out=1 in HALT; fault_out=1 in FAULT.
- Flag precedence in DECODE: j_type first, then SYSCALL check, then execute. Flags are assumed mutually exclusive from the decoder.
- Reset asserted mid-access drops requests immediately (asynchronously); there is no completion of the in-flight access.

Optional Feature:
- Macro: MULTICYCLE_CONTROLLER_PERF_COUNTERS_EN.
- With the macro defined, two 32-bit ports exist in both builds:
  - multicycle_controller_cycle_count_out: increments every cycle not in RESET, HALT or FAULT.
  - multicycle_controller_instret_count_out: increments on each completing transition into FETCH (from DECODE jump, EXECUTE branch, MEM store, WB).
  - Both reset to 0 and wrap at 2^32.
- Without the macro: the ports are still present but tied to 0, so the interface stays stable.

Decomposition:
- Package mips_ctrl_pkg holds:
  - the state enum (3-bit, encodings above);
  - opcode constants LW, SW, BEQ, BNE, J, JAL;
  - the SYSCALL func constant.
- One sub-module, multicycle_controller_stall_timer: counter plus limit compare, with clear/enable inputs and an expired output, parameterised by STALL_LIMIT.

Test Plan:
- R-type ADD, imem_ready on the 1st FETCH cycle -> state sequence 1,2,3,5,1; reg_write high exactly 1 cycle; instret=1.
- LW, dmem_ready after 3 cycles -> MEM lasts 3 cycles with dmem_req=1 and dmem_we=0, then WB with reg_write=1; SW same stimulus -> dmem_we=1, returns to FETCH with no WB.
- J (opcode 000010) -> FETCH, DECODE with pc_write=1, then FETCH; total 2 cycles with imem_ready immediate.
- STALL_LIMIT=4: imem_ready low for 4 cycles -> FAULT on the 5th cycle with fault_out=1 sticky; ready on the 4th cycle -> DECODE with no fault.
- SYSCALL (opcode 0, func 001100) -> HALT; later imem_ready pulses produce no requests; reset asserted -> state=0 asynchronously with all outputs 0.
- Reset asserted during MEM wait -> dmem_req drops the same cycle; after release: RESET, then FETCH.
